// File: rtl/piano_pkg.sv
// Shared definitions for the score sequencer: default widths, score entry
// layout, song base table, score ROM contents and FSM state encoding.
package piano_pkg;

  localparam int P_NOTE_W = 5;
  localparam int P_BEAT_W = 3;
  localparam int P_SONG_W = 2;
  localparam int P_ADDR_W = 8;
  localparam int ENTRY_W  = P_NOTE_W + P_BEAT_W;

  // Note code 0 is silence; an all-zero entry (beats == 0) ends a song.
  localparam logic [P_NOTE_W-1:0] REST     = '0;
  localparam logic [ENTRY_W-1:0]  END_MARK = '0;

  typedef struct packed {
    logic [P_NOTE_W-1:0] note;
    logic [P_BEAT_W-1:0] beats;
  } score_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  function automatic score_entry_t mk_entry(input int unsigned note, input int unsigned beats);
    score_entry_t e;
    e.note  = P_NOTE_W'(note);
    e.beats = P_BEAT_W'(beats);
    return e;
  endfunction

  // First ROM address of each song.
  function automatic logic [P_ADDR_W-1:0] song_base(input int unsigned song);
    logic [P_ADDR_W-1:0] b;
    case (song)
      0:       b = P_ADDR_W'(0);
      1:       b = P_ADDR_W'(8);
      2:       b = P_ADDR_W'(16);
      default: b = P_ADDR_W'(254);
    endcase
    return b;
  endfunction

  // Score contents. Song 1 is empty; song 3 starts two entries before the
  // top of the ROM and runs on through address 0 after the wrap.
  function automatic score_entry_t score_entry(input int unsigned addr);
    score_entry_t e;
    case (addr)
      0:       e = mk_entry(8, 1);
      1:       e = mk_entry(12, 2);
      2:       e = mk_entry(0, 1);
      16:      e = mk_entry(3, 1);
      17:      e = mk_entry(17, 1);
      18:      e = mk_entry(31, 3);
      254:     e = mk_entry(5, 1);
      255:     e = mk_entry(9, 1);
      default: e = score_entry_t'(END_MARK);
    endcase
    return e;
  endfunction

endpackage

// File: rtl/score_sequencer_rom.sv
// Synchronous-read score ROM; data_o updates one cycle after a read request
// and holds its value otherwise.
module score_sequencer_rom
  import piano_pkg::*;
#(
  parameter int ADDR_W = P_ADDR_W,
  parameter int DATA_W = ENTRY_W
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  // Registered table lookup.
  always_ff @(posedge clk) begin
    if (rd_en_i) data_o <= DATA_W'(score_entry(32'(addr_i)));
  end

endmodule

// File: rtl/score_sequencer.sv
// Auto-play engine: walks the score ROM for the selected song, holds each
// note for beats*TICKS_PER_BEAT cycles with a silent gap at its end, and
// drives the note code plus a one-hot LED. Supports pause, stop and loop.
module score_sequencer
  import piano_pkg::*;
#(
  parameter int NOTE_W         = P_NOTE_W,
  parameter int BEAT_W         = P_BEAT_W,
  parameter int SONG_W         = P_SONG_W,
  parameter int ADDR_W         = P_ADDR_W,
  parameter int TICKS_PER_BEAT = 50000000,
  parameter int GAP_TICKS      = 5000000,
  parameter int LED_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [SONG_W-1:0] song_sel,
  output logic [NOTE_W-1:0] note,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  // Longest entry lasts (2**BEAT_W-1)*TICKS_PER_BEAT cycles.
  localparam longint MAX_TICKS = ((longint'(1) << BEAT_W) - 1) * longint'(TICKS_PER_BEAT);
  localparam int     TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int     ROM_W     = NOTE_W + BEAT_W;

  seq_state_e        state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [NOTE_W-1:0] cur_note_q, cur_note_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ROM_W-1:0]  rom_q;
  logic [NOTE_W-1:0] rom_note;
  logic [BEAT_W-1:0] rom_beats;
  logic              rom_rd;

  // Entry length in ticks minus one; product taken at 64 bits before narrowing.
  function automatic logic [TICK_W-1:0] beats_to_ticks(input logic [BEAT_W-1:0] beats);
    longint prod;
    prod = longint'(beats) * longint'(TICKS_PER_BEAT) - longint'(1);
    return TICK_W'(prod);
  endfunction

  // One LED per note, cycling every LED_W note codes; dark for rest.
  function automatic logic [LED_W-1:0] led_onehot(input logic [NOTE_W-1:0] n);
    logic [LED_W-1:0] l;
    l = '0;
    if (n != '0) l = LED_W'(1) << ((int'(n) - 1) % LED_W);
    return l;
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input logic [SONG_W-1:0] s);
    return ADDR_W'(song_base(32'(s)));
  endfunction

  assign rom_rd    = (state_q == ST_FETCH);
  assign rom_note  = rom_q[BEAT_W +: NOTE_W];
  assign rom_beats = rom_q[BEAT_W-1:0];

  score_sequencer_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (ROM_W)
  ) u_rom (
    .clk     (clk),
    .rd_en_i (rom_rd),
    .addr_i  (addr_q),
    .data_o  (rom_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; stop outranks pause, pause outranks start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
        ST_FETCH:         state_d = ST_LOAD;
        ST_LOAD: begin
          if (rom_beats != '0) state_d = pause ? ST_PAUSED : ST_PLAY;
          else                 state_d = loop_en ? ST_FETCH : ST_DONE;
        end
        // The final tick always completes the entry; a held pause is
        // honoured again when the next entry reaches PLAY.
        ST_PLAY: begin
          if (tick_q == '0) state_d = ST_FETCH;
          else if (pause)   state_d = ST_PAUSED;
        end
        ST_PAUSED:        if (!pause) state_d = ST_PLAY;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: song latch, ROM address, entry index, tick counter.
  // The tick counter steps on every PLAY cycle, including the one that
  // enters PAUSED, so each tick is sounded exactly once across a pause.
  always_comb begin
    song_d     = song_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    tick_d     = tick_q;
    cur_note_d = cur_note_q;
    if (stop) begin
      idx_d  = '0;
      tick_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            song_d = song_sel;
            addr_d = base_of(song_sel);
            idx_d  = '0;
          end
        end
        ST_LOAD: begin
          if (rom_beats != '0) begin
            tick_d     = beats_to_ticks(rom_beats);
            cur_note_d = rom_note;
          end else if (loop_en) begin
            addr_d = base_of(song_q);
            idx_d  = '0;
          end
        end
        ST_PLAY: begin
          if (tick_q == '0) begin
            addr_d = addr_q + ADDR_W'(1);
            idx_d  = idx_q + ADDR_W'(1);
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output next values, derived from the upcoming state so the registered
  // outputs line up with state_q.
  always_comb begin
    note_d = NOTE_W'(REST);
    if (state_d == ST_PLAY && tick_d >= TICK_W'(GAP_TICKS)) note_d = cur_note_d;
    led_d  = led_onehot(note_d);
    busy_d = (state_d == ST_FETCH) || (state_d == ST_LOAD) ||
             (state_d == ST_PLAY)  || (state_d == ST_PAUSED);
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q     <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      tick_q     <= '0;
      cur_note_q <= '0;
      note_q     <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      song_q     <= song_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      cur_note_q <= cur_note_d;
      note_q     <= note_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note     = note_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer with short beats (10 cycles) and a 2-cycle gap.
module tb_score_sequencer;

  localparam int TPB = 10;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, pause, stop, loop_en;
  logic [1:0] song_sel;
  logic [4:0] note;
  logic [7:0] led;
  logic       busy, done;
  logic [7:0] note_idx;

  always #5 clk = ~clk;

  score_sequencer #(
    .NOTE_W(5), .BEAT_W(3), .SONG_W(2), .ADDR_W(8),
    .TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP), .LED_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
    .loop_en(loop_en), .song_sel(song_sel), .note(note), .led(led),
    .busy(busy), .done(done), .note_idx(note_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  // Independent copy of the score: note and beat count per address.
  int rom_note [256];
  int rom_beats[256];
  int base     [4];

  // Reference model: where playback stands within the current entry's
  // timeline (pos 0 fetch, pos 1 load, pos 2.. sounding beats).
  typedef enum {M_IDLE, M_BUSY, M_DONE} mode_e;
  mode_e m_mode;
  int    m_song, m_addr, m_idx, m_pos;
  bit    m_paused, m_done;

  task automatic model_reset();
    m_mode = M_IDLE; m_song = 0; m_addr = 0; m_idx = 0; m_pos = 0;
    m_paused = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    int b;
    m_done = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (stop) begin
      m_mode = M_IDLE; m_idx = 0; m_paused = 1'b0;
    end else if (m_mode != M_BUSY) begin
      if (start) begin
        m_mode = M_BUSY; m_song = int'(song_sel); m_addr = base[m_song];
        m_idx = 0; m_pos = 0; m_paused = 1'b0;
      end
    end else begin
      b = rom_beats[m_addr];
      if (m_paused) begin
        if (!pause) m_paused = 1'b0;
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else if (m_pos == 1) begin
        if (b == 0) begin
          if (loop_en) begin m_addr = base[m_song]; m_idx = 0; m_pos = 0; end
          else begin m_mode = M_DONE; m_done = 1'b1; end
        end else begin
          m_pos = 2; m_paused = pause;
        end
      end else if (m_pos == 1 + b * TPB) begin
        m_addr = (m_addr + 1) % 256; m_idx = (m_idx + 1) % 256; m_pos = 0;
      end else begin
        m_pos++; m_paused = pause;
      end
    end
  endtask

  function automatic int exp_note();
    int b;
    if (m_mode != M_BUSY || m_paused || m_pos < 2) return 0;
    b = rom_beats[m_addr];
    if (1 + b * TPB - m_pos >= GAP) return rom_note[m_addr];
    return 0;
  endfunction

  function automatic int led_of(input int n);
    return (n == 0) ? 0 : (1 << ((n - 1) % 8));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int en;
    en = exp_note();
    chk("model note", 32'(note), 32'(en));
    chk("model led", 32'(led), 32'(led_of(en)));
    chk("model busy", 32'(busy), 32'(m_mode == M_BUSY));
    chk("model done", 32'(done), 32'(m_done));
    chk("model note_idx", 32'(note_idx), 32'((m_mode == M_IDLE) ? 0 : m_idx));
  endtask

  // One clock: model follows the same sampled inputs, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  // Directed table: inputs held for cyc cycles, outputs constant across them.
  typedef struct {
    bit st, ps, sp, lp;
    int sel, cyc, nt, ld;
    bit bz, dn;
    int ix;
  } vec_t;
  vec_t tbl[$];

  task automatic add_row(input bit st, input int sel, input int cyc, input int nt,
                         input int ld, input bit bz, input bit dn, input int ix);
    vec_t v;
    v = '{st, 1'b0, 1'b0, 1'b0, sel, cyc, nt, ld, bz, dn, ix};
    tbl.push_back(v);
  endtask

  // Plays until a done pulse or budget; records sounding-note sequence.
  int seen_q[$];
  bit got_done;
  int done_idx;
  int n12;

  task automatic play_to_done(input int budget, input bit jiggle_sel);
    int prev;
    seen_q.delete(); got_done = 1'b0; done_idx = -1; n12 = 0; prev = 0;
    for (int i = 0; i < budget && !got_done; i++) begin
      if (jiggle_sel) song_sel = 2'($urandom);
      step();
      if (note != 5'd0 && int'(note) != prev) seen_q.push_back(int'(note));
      prev = int'(note);
      if (note == 5'd12) n12++;
      if (done) begin got_done = 1'b1; done_idx = int'(note_idx); end
    end
  endtask

  task automatic chk_seq(input string nm, input int e0, input int e1, input int e2,
                         input int e3, input int len);
    int exp_q[$];
    int a;
    exp_q = '{e0, e1, e2, e3};
    chk({nm, " count"}, 32'(seen_q.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      a = (i < seen_q.size()) ? seen_q[i] : -1;
      chk($sformatf("%s note%0d", nm, i), 32'(a), 32'(exp_q[i]));
    end
  endtask

  initial begin
    bit found, seen3, again;
    int s12, nz, ndone;

    for (int a = 0; a < 256; a++) begin rom_note[a] = 0; rom_beats[a] = 0; end
    rom_note[0]   = 8;  rom_beats[0]   = 1;
    rom_note[1]   = 12; rom_beats[1]   = 2;
    rom_note[2]   = 0;  rom_beats[2]   = 1;
    rom_note[16]  = 3;  rom_beats[16]  = 1;
    rom_note[17]  = 17; rom_beats[17]  = 1;
    rom_note[18]  = 31; rom_beats[18]  = 3;
    rom_note[254] = 5;  rom_beats[254] = 1;
    rom_note[255] = 9;  rom_beats[255] = 1;
    base = '{0, 8, 16, 254};

    // Reset
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0; song_sel = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset note", 32'(note), 0);
    chk("reset led", 32'(led), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset note_idx", 32'(note_idx), 0);
    rst_n = 1'b1;

    // Song 0 end to end against hand-derived timing
    add_row(0, 0, 1,  0, 0,    0, 0, 0);
    add_row(1, 0, 1,  0, 0,    1, 0, 0);
    add_row(0, 0, 1,  0, 0,    1, 0, 0);
    add_row(0, 0, 8,  8, 'h80, 1, 0, 0);
    add_row(0, 0, 2,  0, 0,    1, 0, 0);
    add_row(0, 0, 2,  0, 0,    1, 0, 1);
    add_row(0, 0, 18, 12, 'h08, 1, 0, 1);
    add_row(0, 0, 2,  0, 0,    1, 0, 1);
    add_row(0, 0, 2,  0, 0,    1, 0, 2);
    add_row(0, 0, 10, 0, 0,    1, 0, 2);
    add_row(0, 0, 2,  0, 0,    1, 0, 3);
    add_row(0, 0, 1,  0, 0,    0, 1, 3);
    add_row(0, 0, 3,  0, 0,    0, 0, 3);
    foreach (tbl[r]) begin
      start = tbl[r].st; pause = tbl[r].ps; stop = tbl[r].sp; loop_en = tbl[r].lp;
      song_sel = 2'(tbl[r].sel);
      for (int c = 0; c < tbl[r].cyc; c++) begin
        step();
        chk($sformatf("row%0d note", r), 32'(note), 32'(tbl[r].nt));
        chk($sformatf("row%0d led", r), 32'(led), 32'(tbl[r].ld));
        chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].bz));
        chk($sformatf("row%0d done", r), 32'(done), 32'(tbl[r].dn));
        chk($sformatf("row%0d note_idx", r), 32'(note_idx), 32'(tbl[r].ix));
      end
    end
    start = 1'b0;

    // Loop: restarts from entry 0 with no done pulse
    song_sel = 2'd0; loop_en = 1'b1; start = 1'b1; step(); start = 1'b0;
    ndone = 0; seen3 = 1'b0; again = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (done) ndone++;
      if (note_idx == 8'd3) seen3 = 1'b1;
      if (seen3 && note == 5'd8 && note_idx == 8'd0) again = 1'b1;
    end
    chk("loop no done", 32'(ndone), 0);
    chk("loop restart", 32'(again), 1);
    stop = 1'b1; step(); stop = 1'b0; loop_en = 1'b0;

    // Pause 3 cycles into note 12 for 20 cycles
    song_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (note == 5'd12) found = 1'b1;
    end
    chk("pause reach note12", 32'(found), 1);
    s12 = found ? 1 : 0;
    for (int i = 0; i < 2; i++) begin step(); if (note == 5'd12) s12++; end
    pause = 1'b1; nz = 0;
    for (int i = 0; i < 20; i++) begin step(); if (note != 5'd0) nz++; end
    pause = 1'b0;
    chk("pause silent", 32'(nz), 0);
    play_to_done(100, 1'b0);
    chk("pause note12 length", 32'(s12 + n12), 18);
    chk("pause done", 32'(got_done), 1);

    // Stop mid-note, then a different song starts cleanly
    song_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop note", 32'(note), 0);
    chk("stop busy", 32'(busy), 0);
    chk("stop note_idx", 32'(note_idx), 0);
    song_sel = 2'd2; start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("restart note", 32'(note), 3);
    chk("restart led", 32'(led), 'h04);
    stop = 1'b1; step(); stop = 1'b0;

    // Empty song goes straight to DONE; song_sel moves while busy
    song_sel = 2'd1; start = 1'b1; step(); start = 1'b0; song_sel = 2'd2;
    nz = 0;
    step(); if (note != 5'd0) nz++;
    step(); if (note != 5'd0) nz++;
    chk("empty done", 32'(done), 1);
    chk("empty busy", 32'(busy), 0);
    repeat (2) begin step(); if (note != 5'd0) nz++; end
    chk("empty silent", 32'(nz), 0);

    // Song 2 with song_sel jiggling throughout
    song_sel = 2'd2; start = 1'b1; step(); start = 1'b0;
    play_to_done(200, 1'b1);
    chk("jiggle done", 32'(got_done), 1);
    chk_seq("jiggle", 3, 17, 31, 0, 3);

    // Song 3 crosses the top of the ROM into address 0
    song_sel = 2'd3; start = 1'b1; step(); start = 1'b0;
    play_to_done(200, 1'b0);
    chk("wrap done", 32'(got_done), 1);
    chk("wrap idx at done", 32'(done_idx), 5);
    chk_seq("wrap", 5, 9, 8, 12, 4);

    // Asynchronous reset mid-note
    song_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst note", 32'(note), 0);
    chk("async rst led", 32'(led), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst note_idx", 32'(note_idx), 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    song_sel = 2'd2; start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("post rst note", 32'(note), 3);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      stop  = ($urandom % 64) == 0;
      start = ($urandom % 8) == 0;
      if (($urandom % 16) == 0) pause = ~pause;
      if (($urandom % 200) == 0) loop_en = ~loop_en;
      song_sel = 2'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
